// File: rtl/button_event.sv
// Turns a debounced button level into one-cycle short press, long press and
// double click pulses, timed by a single shared sample counter.
module button_event #(
    parameter int LONG_CNT = 8,
    parameter int DBL_WIN  = 4,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             short_nxt;
    logic             long_nxt;
    logic             double_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_click <= double_nxt;
        end
    end

    // The counter restarts at 1 on every phase change, so it counts samples
    // of the current level including the one that entered the phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (btn) begin
                    state_nxt = PRESS1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (!btn) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            WAIT2: begin
                if (btn) begin
                    state_nxt = PRESS2;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == DBL_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!btn) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!btn) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        busy       = (state != IDLE);
        case (state)
            PRESS1:  long_nxt   = btn && (cnt == LONG_LAST);
            WAIT2:   short_nxt  = !btn && (cnt == DBL_LAST);
            PRESS2: begin
                double_nxt = !btn;
                long_nxt   = btn && (cnt == LONG_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: stimulus queues expected pulses with the
// cycle they must appear in, a monitor matches every observed pulse.
module tb_button_event;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_DOUBLE = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    button_event #(.LONG_CNT(8), .DBL_WIN(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Each call sets btn for n consecutive samples, changing it on the falling edge.
    task automatic applyStimulus(input logic level, input int n);
        repeat (n) begin
            @(negedge clk);
            btn = level;
        end
    endtask

    // The last sample set is taken at the next rising edge, cycle cyc+1.
    task automatic expectPulse(input int kind, input int offset);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 1 + offset;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse observed must match the oldest expectation;
    // an expectation whose cycle has passed is reported as missing.
    always @(negedge clk) begin
        int   seen;
        exp_t e;
        seen = 0;
        if (short_press)  seen = K_SHORT;
        if (long_press)   seen = (seen != 0) ? 7 : K_LONG;
        if (double_click) seen = (seen != 0) ? 7 : K_DOUBLE;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checkOutput("missing_pulse_kind", 0, e.kind);
        end
        if (seen != 0) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse_kind", seen, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", seen, e.kind);
                checkOutput("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulses", int'({short_press, long_press, double_click}), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3);

        // Short press: 3 high, then short_press on the 4th low sample
        applyStimulus(1'b1, 3);
        checkOutput("busy_in_press", int'(busy), 1);
        applyStimulus(1'b0, 4);
        expectPulse(K_SHORT, 0);
        applyStimulus(1'b0, 2);
        checkOutput("busy_after_short", int'(busy), 0);

        // Long press held 20 samples
        applyStimulus(1'b1, 8);
        expectPulse(K_LONG, 0);
        applyStimulus(1'b1, 12);
        checkOutput("busy_long_held", int'(busy), 1);
        applyStimulus(1'b0, 6);
        checkOutput("busy_after_long", int'(busy), 0);

        // Double click: high 2, low 2, high 2, low
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        expectPulse(K_DOUBLE, 0);
        applyStimulus(1'b0, 1);
        checkOutput("busy_after_double", int'(busy), 0);
        applyStimulus(1'b0, 5);

        // 7 high samples is still a short press
        applyStimulus(1'b1, 7);
        applyStimulus(1'b0, 4);
        expectPulse(K_SHORT, 0);
        applyStimulus(1'b0, 3);

        // Gap of exactly 4 lows splits into two short presses
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 4);
        expectPulse(K_SHORT, 0);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 4);
        expectPulse(K_SHORT, 0);
        applyStimulus(1'b0, 3);

        // Gap of 3 lows still a double click
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        expectPulse(K_DOUBLE, 0);
        applyStimulus(1'b0, 5);

        // Second press held long
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 8);
        expectPulse(K_LONG, 0);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 6);
        checkOutput("busy_after_press2_long", int'(busy), 0);

        // Reset mid-press after 5 high samples, button kept high
        applyStimulus(1'b1, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_pulses", int'({short_press, long_press, double_click}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expectPulse(K_LONG, 7);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 8);
        checkOutput("busy_end", int'(busy), 0);

        applyStimulus(1'b0, 2);
        checkOutput("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/button_event.md
# button_event

Classifies presses on a clean, debounced button level into single-cycle event pulses: short press, long press, and double click. It sits directly downstream of the switch debouncer. It consumes the debouncer's registered output and feeds event pulses to lab control logic such as mode selects and counters. Default parameter values are deliberately small for simulation; synthesis builds override them.

## Interface
- LONG_CNT, default 8: consecutive high samples that make a long press; legal range 2 to 2^CNT_W-1.
- DBL_WIN, default 4: consecutive low samples after a short press that close the double-click window; legal range 2 to 2^CNT_W-1.
- CNT_W, default 4: width of the shared cycle counter.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  1  debounced button level, active-high, synchronous to clk.
- short_press  output  1  registered one-cycle pulse marking a single short press.
- long_press  output  1  registered one-cycle pulse marking a long press.
- double_click  output  1  registered one-cycle pulse marking two short presses within the window.
- busy  output  1  high whenever the state is not IDLE; decoded from the state register.

## Operation
- Reset state: IDLE, cnt=0, all pulse outputs 0, busy=0.
- "Sample" means the value of btn at a rising clk edge. All rules below are evaluated per edge.
- Pulse outputs default to 0 every edge. At most one pulse is asserted in any cycle.
- State transitions:
  - IDLE, btn=1: go to PRESS1, cnt<=1. IDLE, btn=0: stay.
  - PRESS1, btn=0: go to WAIT2, cnt<=1.
  - PRESS1, btn=1, cnt==LONG_CNT-1: set long_press<=1, go to LONG_HELD.
  - PRESS1, btn=1, otherwise: cnt<=cnt+1.
  - WAIT2, btn=1: go to PRESS2, cnt<=1.
  - WAIT2, btn=0, cnt==DBL_WIN-1: set short_press<=1, go to IDLE.
  - WAIT2, btn=0, otherwise: cnt<=cnt+1.
  - PRESS2, btn=0: set double_click<=1, go to IDLE.
  - PRESS2, btn=1, cnt==LONG_CNT-1: set long_press<=1, go to LONG_HELD. The pending first press is discarded and no short_press is issued.
  - PRESS2, btn=1, otherwise: cnt<=cnt+1.
  - LONG_HELD, btn=0: go to IDLE. LONG_HELD, btn=1: stay, with no further pulses.
- Illegal state encodings: recover to IDLE at the next edge with cnt=0 and no pulse.
- Counter width: cnt never exceeds max(LONG_CNT, DBL_WIN)-1, so it never wraps. No arithmetic is wider than CNT_W.
- Reset mid-operation: the FSM returns to IDLE immediately and no pending pulse is emitted. If btn is already high at the first edge after reset, that edge counts as a new press start.

## Timing
- Input to event latency is one edge. Each pulse is high for exactly the cycle following the edge that decided it.
- long_press: the cycle after the LONG_CNT-th consecutive high sample, counted from the press start. It fires while the button is still held.
- short_press: the cycle after the DBL_WIN-th consecutive low sample following a press of 1 to LONG_CNT-1 high samples.
- double_click: the cycle after the first low sample of the second press.
- Gap boundary: a low gap of DBL_WIN-1 samples still qualifies as a double click. A gap of exactly DBL_WIN samples yields a short press, and the next press starts a fresh sequence.
- Press-length boundary: LONG_CNT-1 high samples is a short press; LONG_CNT high samples is a long press.
- busy rises the cycle after the press-start edge. It falls in the same cycle the terminal pulse is visible, or the cycle after release from LONG_HELD.

## Test plan
- Short press, defaults: btn high for 3 samples, then low. Required: short_press high for exactly 1 cycle after the 4th low sample; no long_press or double_click.
- Long press: btn high for 20 samples. Required: long_press high for 1 cycle after the 8th high sample and never again; after release there is no short_press and busy returns to 0.
- Double click: btn high 2, low 2, high 2, then low. Required: double_click for 1 cycle after the first low sample of the second press; no short_press.
- Boundaries:
  - High 7 samples, then low: short_press, not long_press.
  - High 2, low 4, high 2, low: short_press after the 4th low sample, then a separate short_press for the second press.
  - High 2, low 3, high 2, low: double_click.
- Second press held long: high 2, low 1, high 10. Required: long_press after the 8th high sample of the second press; no short_press or double_click.
- Reset mid-press: assert rst_n=0 while in PRESS1 after 5 high samples. Required: all outputs 0 asynchronously; with btn held high through release, long_press fires after 8 samples counted from the first post-reset edge.
